request_handler: RTL and testbench
==================================

Name: request_handler

Overview:
- Decodes two-byte host commands from the UART receive path into a per-device request.
- Byte 1 is the device address and byte 2 is the request code.
- A valid address drives a one-hot device selector and a single-cycle request strobe toward the sensor controllers.
- It sits between the UART receiver and the sensor-interface array.

Parameters:
- NUM_DEVICES, 32: number of addressable devices; address valid iff < NUM_DEVICES; max 32 (selector width).
- TIMEOUT_CYCLES, 1000: idle cycles allowed between address byte and request byte before abort.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  byte-valid: received_data carries a new byte on every rising edge where enable=1.
- received_data  input  8  byte from UART receiver.
- has_request  output  1  one-cycle strobe: new valid request issued.
- request  output  8  latched request code.
- device_selected  output  1  high while a valid device selection is held.
- device_selector  output  32  one-hot device select; bit[address]=1.
- debug_state  output  3  current FSM state encoding.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - has_request=0, request=0, device_selected=0, device_selector=0.
  - Address/command registers and timeout counter cleared.
  - Reset mid-transaction discards all partial bytes.
- All outputs are registered. debug_state equals the state register.
- IDLE (3'd0): on edge with enable=1, latch received_data as address → RECV_CMD. Otherwise stay.
- RECV_CMD (3'd1):
  - On edge with enable=1: latch received_data as command, clear counter → DECODE.
  - Each edge with enable=0: counter+1.
  - When counter reaches TIMEOUT_CYCLES-1 → IDLE; address discarded; outputs unchanged.
- DECODE (3'd2): enable ignored.
  - If address < NUM_DEVICES → ISSUE.
  - Otherwise → ERROR.
- ISSUE (3'd3), on the edge entering ISSUE:
  - has_request=1, request=command.
  - device_selector=1<<address, device_selected=1.
  - Next edge: has_request=0 → IDLE.
  - request, device_selector and device_selected hold until the next ISSUE, ERROR or reset.
- ERROR (3'd4), on the edge entering ERROR:
  - device_selected=0, device_selector=0, request=0, has_request=0.
  - Next edge → IDLE.
- Codes 5–7 unused; if reached, return to IDLE on the next edge with outputs unchanged.
- Latency:
  - Command byte accepted at edge N.
  - DECODE during cycle N..N+1.
  - has_request high from edge N+1 to N+2.
  - IDLE again after edge N+2.
- enable high in DECODE, ISSUE or ERROR: byte dropped (no buffering).
  - enable held high continuously therefore starts a new transaction on the first IDLE cycle.
- device_selector is always one-hot or all-zero; never multiple bits.
- Request code is not validated; any of 0x00–0xFF is forwarded.

Test Plan:
- Reset: assert reset=0 mid-RECV_CMD → immediately debug_state=0 and all outputs 0; release, then send 0x03, 0x01 → normal issue.
- Valid request: enable=1 with 0x05 then 0x20 on consecutive edges → two edges later has_request=1 for exactly one cycle, request=0x20, device_selector=0x0000_0020, device_selected=1, debug_state sequence 0,1,2,3,0.
- Invalid address: 0xFF then 0x20 → debug_state 0,1,2,4,0; has_request stays 0; device_selector=0, device_selected=0, request=0 (clears a prior valid selection).
- Timeout: send 0x07 then hold enable=0 for TIMEOUT_CYCLES cycles → back to IDLE, no has_request; next bytes 0x01, 0x10 → device_selector=0x2, request=0x10.
- Boundary addresses: 0x00/0xAA → selector 0x0000_0001, request 0xAA; 0x1F/0x55 → selector 0x8000_0000, request 0x55; 0x20 → ERROR path.
- Held enable: enable=1 continuously with data 0x20 after a transaction → the byte presented in the first IDLE cycle is captured as a new address; bytes presented during DECODE/ISSUE are ignored.

Source files
------------

// File: rtl/request_handler.sv
`default_nettype none
// ============================================================================
// request_handler - turns (address, request) byte pairs into a one-hot device
// select plus a single-cycle request strobe.                       Rev 1.0
// ============================================================================
module request_handler #(
  parameter int NUM_DEVICES    = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  received_data,
  output logic        has_request,
  output logic [7:0]  request,
  output logic        device_selected,
  output logic [31:0] device_selector,
  output logic [2:0]  debug_state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0] NUM_DEV = 9'(NUM_DEVICES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RECV_CMD = 3'd1,
    S_DECODE   = 3'd2,
    S_ISSUE    = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [7:0]       address, address_next;
  logic [7:0]       command, command_next;
  logic [CNT_W-1:0] counter, counter_next;
  logic             has_request_next;
  logic [7:0]       request_next;
  logic             device_selected_next;
  logic [31:0]      device_selector_next;
  logic             address_valid;

  assign address_valid = ({1'b0, address} < NUM_DEV);
  assign debug_state   = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      address         <= 8'd0;
      command         <= 8'd0;
      counter         <= '0;
      has_request     <= 1'b0;
      request         <= 8'd0;
      device_selected <= 1'b0;
      device_selector <= 32'd0;
    end else begin
      state           <= state_next;
      address         <= address_next;
      command         <= command_next;
      counter         <= counter_next;
      has_request     <= has_request_next;
      request         <= request_next;
      device_selected <= device_selected_next;
      device_selector <= device_selector_next;
    end
  end

  always_comb begin
    state_next           = state;
    address_next         = address;
    command_next         = command;
    counter_next         = counter;
    has_request_next     = 1'b0;
    request_next         = request;
    device_selected_next = device_selected;
    device_selector_next = device_selector;

    case (state)
      S_IDLE: begin
        if (enable) begin
          address_next = received_data;
          counter_next = '0;
          state_next   = S_RECV_CMD;
        end
      end
      S_RECV_CMD: begin
        // A byte arriving on the final idle edge still wins over the timeout.
        if (enable) begin
          command_next = received_data;
          counter_next = '0;
          state_next   = S_DECODE;
        end else if (counter == CNT_LAST) begin
          counter_next = '0;
          state_next   = S_IDLE;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      S_DECODE: begin
        if (address_valid) begin
          has_request_next     = 1'b1;
          request_next         = command;
          device_selector_next = 32'd1 << address[4:0];
          device_selected_next = 1'b1;
          state_next           = S_ISSUE;
        end else begin
          request_next         = 8'd0;
          device_selector_next = 32'd0;
          device_selected_next = 1'b0;
          state_next           = S_ERROR;
        end
      end
      S_ISSUE:  state_next = S_IDLE;
      S_ERROR:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_request_handler.sv
`default_nettype none
// tb_request_handler - randomized and directed checks of request_handler
// against a transaction-level timing model.
module tb_request_handler;

  localparam int NDEV = 32;
  localparam int TO   = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  received_data = 8'd0;
  logic        has_request;
  logic [7:0]  request;
  logic        device_selected;
  logic [31:0] device_selector;
  logic [2:0]  debug_state;

  request_handler #(.NUM_DEVICES(NDEV), .TIMEOUT_CYCLES(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .received_data   (received_data),
    .has_request     (has_request),
    .request         (request),
    .device_selected (device_selected),
    .device_selector (device_selector),
    .debug_state     (debug_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks when the address byte and command byte were taken (edge
  // index) and derives the visible outputs from those timestamps.
  longint      cyc = 0;
  bit          have_addr = 0;
  longint      addr_cyc = 0;
  longint      cmd_cyc = -100;
  longint      busy_end = 0;
  logic [7:0]  m_addr = 8'd0;
  logic [7:0]  m_cmd = 8'd0;
  bit          m_valid = 0;
  logic        m_hr = 1'b0;
  logic        m_seld = 1'b0;
  logic [7:0]  m_req = 8'd0;
  logic [31:0] m_sel = 32'd0;
  logic [2:0]  m_dbg = 3'd0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      have_addr = 0;
      cmd_cyc   = -100;
      busy_end  = 0;
      m_hr = 1'b0; m_seld = 1'b0; m_req = 8'd0; m_sel = 32'd0; m_dbg = 3'd0;
    end else begin
      cyc++;
      m_hr = 1'b0;
      if (cyc == cmd_cyc + 1) begin
        if (m_valid) begin
          m_hr = 1'b1; m_req = m_cmd; m_sel = 32'd1 << m_addr; m_seld = 1'b1;
        end else begin
          m_req = 8'd0; m_sel = 32'd0; m_seld = 1'b0;
        end
      end
      if (cyc < busy_end) begin
        // byte (if any) is dropped while the pair is being resolved
      end else if (!have_addr) begin
        if (enable) begin
          have_addr = 1; m_addr = received_data; addr_cyc = cyc;
        end
      end else if (enable) begin
        have_addr = 0; m_cmd = received_data; cmd_cyc = cyc;
        busy_end  = cyc + 3;
        m_valid   = (int'(m_addr) < NDEV);
      end else if (cyc - addr_cyc == TO) begin
        have_addr = 0;
      end
      if (cyc == cmd_cyc)          m_dbg = 3'd2;
      else if (cyc == cmd_cyc + 1) m_dbg = m_valid ? 3'd3 : 3'd4;
      else                         m_dbg = have_addr ? 3'd1 : 3'd0;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("debug_state",     32'(debug_state),     32'(m_dbg));
      chk("has_request",     32'(has_request),     32'(m_hr));
      chk("request",         32'(request),         32'(m_req));
      chk("device_selected", 32'(device_selected), 32'(m_seld));
      chk("device_selector", device_selector,      m_sel);
    end
  end

  task automatic put(input logic [7:0] b);
    enable = 1'b1;
    received_data = b;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] c,
                     input logic [31:0] exp_sel, input logic [7:0] exp_req, input bit ok);
    put(a);
    put(c);
    enable = 1'b0;
    chk("lit_dbg_decode", 32'(debug_state), 32'd2);
    @(negedge clock);
    chk("lit_strobe",   32'(has_request),     ok ? 32'd1 : 32'd0);
    chk("lit_dbg_res",  32'(debug_state),     ok ? 32'd3 : 32'd4);
    chk("lit_selector", device_selector,      exp_sel);
    chk("lit_selected", 32'(device_selected), ok ? 32'd1 : 32'd0);
    chk("lit_request",  32'(request),         32'(exp_req));
    @(negedge clock);
    chk("lit_strobe_off", 32'(has_request), 32'd0);
    chk("lit_dbg_idle",   32'(debug_state), 32'd0);
    chk("lit_sel_hold",   device_selector,  exp_sel);
  endtask

  initial begin
    logic [7:0] d;
    int gap;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("lit_rst_dbg", 32'(debug_state), 32'd0);
    chk("lit_rst_sel", device_selector, 32'd0);
    chk("lit_rst_req", 32'(request), 32'd0);

    txn(8'h05, 8'h20, 32'h0000_0020, 8'h20, 1);
    txn(8'hFF, 8'h20, 32'h0000_0000, 8'h00, 0);

    // Reset in the middle of a pair
    put(8'h07);
    enable = 1'b0;
    chk("lit_mid_dbg", 32'(debug_state), 32'd1);
    reset = 1'b0;
    #1;
    chk("lit_arst_dbg", 32'(debug_state), 32'd0);
    chk("lit_arst_hr",  32'(has_request), 32'd0);
    chk("lit_arst_sel", device_selector,  32'd0);
    @(negedge clock);
    reset = 1'b1;
    txn(8'h03, 8'h01, 32'h0000_0008, 8'h01, 1);

    // Timeout after the address byte
    put(8'h07);
    idle(TO - 1);
    chk("lit_to_wait", 32'(debug_state), 32'd1);
    idle(1);
    chk("lit_to_idle", 32'(debug_state), 32'd0);
    chk("lit_to_hr",   32'(has_request), 32'd0);
    txn(8'h01, 8'h10, 32'h0000_0002, 8'h10, 1);

    txn(8'h00, 8'hAA, 32'h0000_0001, 8'hAA, 1);
    txn(8'h1F, 8'h55, 32'h8000_0000, 8'h55, 1);
    txn(8'h20, 8'h11, 32'h0000_0000, 8'h00, 0);

    // Enable held high across the resolve cycles
    put(8'h02);
    put(8'h33);
    received_data = 8'h20;
    repeat (3) @(negedge clock);
    chk("lit_held_addr", 32'(debug_state), 32'd1);
    @(negedge clock);
    chk("lit_held_dec", 32'(debug_state), 32'd2);
    @(negedge clock);
    chk("lit_held_err", 32'(debug_state), 32'd4);
    idle(3);

    for (int i = 0; i < 800; i++) begin
      gap = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 3);
      idle(gap);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      put(d);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
      end
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
